// File: rtl/iter_muldiv_if.sv
// rtl/iter_muldiv_if.sv - request/response bundle for the iterative multiply/divide unit
interface iter_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] busA;
  logic [WIDTH-1:0] busB;
  logic [WIDTH-1:0] resultLo;
  logic [WIDTH-1:0] resultHi;
  logic             done;
  logic             multStall;
  logic             divZero;
  logic             overflow;

  modport master (
    output start, op, busA, busB,
    input  resultLo, resultHi, done, multStall, divZero, overflow
  );

  modport slave (
    input  start, op, busA, busB,
    output resultLo, resultHi, done, multStall, divZero, overflow
  );
endinterface

// File: rtl/iter_muldiv_unit.sv
// rtl/iter_muldiv_unit.sv - iterative shift-add multiplier / restoring divider, signed and unsigned
module iter_muldiv_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic         clock,
  input  logic         reset,
  iter_muldiv_if.slave bus
);
  localparam int W  = WIDTH;
  localparam int B  = BITS_PER_CYCLE;
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  logic [1:0]    state_q, state_d;
  logic          is_div_q, is_div_d;
  logic [W-1:0]  opnd_q, opnd_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  raw_a_q, raw_a_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_lo_q, neg_lo_d;
  logic          neg_hi_q, neg_hi_d;
  logic          dz_q, dz_d;
  logic          ovf_q, ovf_d;
  logic [W-1:0]  res_lo_q, res_lo_d;
  logic [W-1:0]  res_hi_q, res_hi_d;
  logic          done_q, done_d;
  logic          div_zero_q, div_zero_d;
  logic          overflow_q, overflow_d;

  logic          sign_a, sign_b;
  logic [W-1:0]  mag_a, mag_b;
  logic [B-1:0]  digit;
  logic [W+B-1:0] pp, psum;
  logic [PW-1:0] mul_next;
  logic [W:0]    rem_shift;
  logic          rem_ge;
  logic [W-1:0]  rem_sub;
  logic [PW-1:0] prod_fix;

  // Negating MIN yields MIN, which read unsigned is exactly 2^(W-1).
  always_comb begin
    sign_a = ~bus.op[0] & bus.busA[W-1];
    sign_b = ~bus.op[0] & bus.busB[W-1];
    mag_a  = sign_a ? -bus.busA : bus.busA;
    mag_b  = sign_b ? -bus.busB : bus.busB;
  end

  // Multiply: {hi,lo} holds partial product above the unconsumed multiplier bits.
  always_comb begin
    digit    = lo_q[B-1:0];
    pp       = {{B{1'b0}}, opnd_q} * {{W{1'b0}}, digit};
    psum     = {{B{1'b0}}, hi_q} + pp;
    mul_next = PW'({psum, lo_q} >> B);
  end

  always_comb begin
    rem_shift = {hi_q, lo_q[W-1]};
    rem_ge    = rem_shift >= {1'b0, opnd_q};
    rem_sub   = rem_shift[W-1:0] - opnd_q;
    prod_fix  = neg_lo_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  end

  always_comb begin
    state_d    = state_q;
    is_div_d   = is_div_q;
    opnd_d     = opnd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    raw_a_d    = raw_a_q;
    cnt_d      = cnt_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    dz_d       = dz_q;
    ovf_d      = ovf_q;
    res_lo_d   = res_lo_q;
    res_hi_d   = res_hi_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    overflow_d = overflow_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          is_div_d = bus.op[1];
          raw_a_d  = bus.busA;
          hi_d     = '0;
          neg_lo_d = sign_a ^ sign_b;
          neg_hi_d = sign_a;
          dz_d     = bus.op[1] & (bus.busB == '0);
          ovf_d    = (bus.op == 2'b10) & (bus.busA == MIN_VAL) & (bus.busB == '1);
          if (bus.op[1]) begin
            opnd_d = mag_b;
            lo_d   = mag_a;
            cnt_d  = CW'(W);
          end else begin
            opnd_d = mag_a;
            lo_d   = mag_b;
            cnt_d  = CW'(W / B);
          end
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          hi_d = rem_ge ? rem_sub : rem_shift[W-1:0];
          lo_d = {lo_q[W-2:0], rem_ge};
        end else begin
          {hi_d, lo_d} = mul_next;
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d    = S_IDLE;
        done_d     = 1'b1;
        div_zero_d = dz_q;
        overflow_d = ovf_q;
        if (!is_div_q) begin
          {res_hi_d, res_lo_d} = prod_fix;
        end else if (dz_q) begin
          res_lo_d = '1;
          res_hi_d = raw_a_q;
        end else if (ovf_q) begin
          res_lo_d = MIN_VAL;
          res_hi_d = '0;
        end else begin
          res_lo_d = neg_lo_q ? -lo_q : lo_q;
          res_hi_d = neg_hi_q ? -hi_q : hi_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      is_div_q   <= 1'b0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      raw_a_q    <= '0;
      cnt_q      <= '0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      dz_q       <= 1'b0;
      ovf_q      <= 1'b0;
      res_lo_q   <= '0;
      res_hi_q   <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_div_q   <= is_div_d;
      opnd_q     <= opnd_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      raw_a_q    <= raw_a_d;
      cnt_q      <= cnt_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      dz_q       <= dz_d;
      ovf_q      <= ovf_d;
      res_lo_q   <= res_lo_d;
      res_hi_q   <= res_hi_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.resultLo  = res_lo_q;
  assign bus.resultHi  = res_hi_q;
  assign bus.done      = done_q;
  assign bus.divZero   = div_zero_q;
  assign bus.overflow  = overflow_q;
  assign bus.multStall = (state_q != S_IDLE) | bus.start;
endmodule

// File: tb/tb_iter_muldiv_unit.sv
// tb/tb_iter_muldiv_unit.sv - scoreboard bench for iter_muldiv_unit at BPC=1 and BPC=4
module tb_iter_muldiv_unit;
  localparam logic [1:0] OP_MUL = 2'b00, OP_MULU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    logic        ovf;
  } exp_t;

  logic clock;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q1[$];
  exp_t q4[$];
  exp_t e1, e4;

  iter_muldiv_if #(.WIDTH(32)) ifc1 ();
  iter_muldiv_if #(.WIDTH(32)) ifc4 ();

  iter_muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut1 (.clock(clock), .reset(reset), .bus(ifc1.slave));
  iter_muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (.clock(clock), .reset(reset), .bus(ifc4.slave));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic st, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (sel) begin
      ifc4.start = st; ifc4.op = op; ifc4.busA = a; ifc4.busB = b;
    end else begin
      ifc1.start = st; ifc1.op = op; ifc1.busA = a; ifc1.busB = b;
    end
  endtask

  function automatic logic get_done(input bit sel);
    return sel ? ifc4.done : ifc1.done;
  endfunction

  function automatic logic get_stall(input bit sel);
    return sel ? ifc4.multStall : ifc1.multStall;
  endfunction

  always @(negedge clock) begin
    if (ifc1.done) begin
      if (q1.size() == 0) chk("done1_unexpected", 1, 0);
      else begin
        e1 = q1.pop_front();
        chk("bpc1_lo", ifc1.resultLo, e1.lo);
        chk("bpc1_hi", ifc1.resultHi, e1.hi);
        chk("bpc1_divzero", ifc1.divZero, e1.dz);
        chk("bpc1_overflow", ifc1.overflow, e1.ovf);
      end
    end
  end

  always @(negedge clock) begin
    if (ifc4.done) begin
      if (q4.size() == 0) chk("done4_unexpected", 1, 0);
      else begin
        e4 = q4.pop_front();
        chk("bpc4_lo", ifc4.resultLo, e4.lo);
        chk("bpc4_hi", ifc4.resultHi, e4.hi);
        chk("bpc4_divzero", ifc4.divZero, e4.dz);
        chk("bpc4_overflow", ifc4.overflow, e4.ovf);
      end
    end
  end

  // Edges are counted with the start edge as edge 1; stall counts cycles after the start edge.
  task automatic run_op(input bit sel, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] elo, input logic [31:0] ehi, input logic edz, input logic eovf,
                        input int exp_lat, input int exp_stall);
    exp_t e;
    int   edges, stall;
    bit   seen;
    e = '{lo: elo, hi: ehi, dz: edz, ovf: eovf};
    @(negedge clock);
    drive(sel, 1'b1, op, a, b);
    if (sel) q4.push_back(e); else q1.push_back(e);
    @(posedge clock);
    #1;
    drive(sel, 1'b0, ~op, $urandom, $urandom);
    edges = 1; stall = 0; seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clock);
      if (get_done(sel)) seen = 1;
      else begin
        if (get_stall(sel)) stall++;
        @(posedge clock);
        edges++;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    else begin
      if (exp_lat > 0) chk("latency", edges, exp_lat);
      if (exp_stall > 0) chk("stall_cycles", stall, exp_stall);
      chk("stall_in_done_cycle", get_stall(sel), 0);
    end
  endtask

  initial begin
    bit seen;
    drive(0, 1'b0, 2'b00, 0, 0);
    drive(1, 1'b0, 2'b00, 0, 0);
    reset = 1'b1;
    #12;
    chk("reset_lo", ifc1.resultLo, 0);
    chk("reset_hi", ifc1.resultHi, 0);
    chk("reset_done", ifc1.done, 0);
    chk("reset_flags", {ifc1.divZero, ifc1.overflow}, 0);
    chk("reset_stall", ifc1.multStall, 0);
    @(negedge clock);
    reset = 1'b0;

    run_op(0, OP_MULU, 5000, 2, 10000, 0, 0, 0, 34, 33);
    run_op(0, OP_MUL, 32'hFFFFFFFD, 7, 32'hFFFFFFEB, 32'hFFFFFFFF, 0, 0, 0, 0);
    run_op(0, OP_DIV, 32'hFFFFEC78, 3, 32'hFFFFF97E, 32'hFFFFFFFE, 0, 0, 34, 33);
    run_op(0, OP_DIVU, 5000, 3, 1666, 2, 0, 0, 34, 0);
    run_op(0, OP_DIVU, 7, 0, 32'hFFFFFFFF, 7, 1, 0, 0, 0);
    run_op(0, OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0, 1, 0, 0);
    run_op(0, OP_MUL, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0, 0, 0, 0);
    run_op(0, OP_DIV, 7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1, 0, 0, 0, 0);
    run_op(0, OP_DIV, 32'hFFFFFFF9, 2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 0, 0, 0);
    run_op(0, OP_DIV, 32'hFFFFFFF9, 0, 32'hFFFFFFFF, 32'hFFFFFFF9, 1, 0, 0, 0);

    run_op(1, OP_MUL, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001, 32'h3FFFFFFF, 0, 0, 10, 9);
    run_op(1, OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 0, 0, 10, 0);
    run_op(1, OP_DIVU, 100, 7, 14, 2, 0, 0, 34, 33);

    // Start held high: the mid-RUN operand change must be ignored, then taken in the done cycle.
    @(negedge clock);
    drive(0, 1'b1, OP_MULU, 3, 4);
    q1.push_back('{lo: 12, hi: 0, dz: 0, ovf: 0});
    q1.push_back('{lo: 14, hi: 2, dz: 0, ovf: 0});
    repeat (6) @(posedge clock);
    #1;
    drive(0, 1'b1, OP_DIVU, 100, 7);
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clock);
      if (ifc1.done) seen = 1;
    end
    if (!seen) chk("b2b_first_timeout", 0, 1);
    else chk("b2b_stall_with_start", ifc1.multStall, 1);
    @(posedge clock);
    #1;
    drive(0, 1'b0, OP_MUL, 32'hDEADBEEF, 32'h12345678);
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clock);
      if (ifc1.done) seen = 1;
    end
    if (!seen) chk("b2b_second_timeout", 0, 1);

    // Abort in RUN via asynchronous reset.
    @(negedge clock);
    drive(0, 1'b1, OP_MULU, 9, 9);
    @(posedge clock);
    #1;
    drive(0, 1'b0, OP_MULU, 0, 0);
    repeat (4) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_stall", ifc1.multStall, 0);
    chk("abort_lo", ifc1.resultLo, 0);
    chk("abort_hi", ifc1.resultHi, 0);
    chk("abort_done", ifc1.done, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    run_op(0, OP_MULU, 6, 7, 42, 0, 0, 0, 34, 0);

    repeat (3) @(negedge clock);
    chk("q1_drained", q1.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
